// File: rtl/bcd_share_arbiter.sv
// Round-robin sharing of one pipelined binary-to-BCD converter among N requesters.
// A grant registers the requester's value, waits out CONV_LAT, then returns the tagged result with an ack.
module bcd_share_arbiter #(
    parameter int N        = 3,
    parameter int IDW      = 2,
    parameter int CONV_LAT = 2
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST,
    input  logic [N-1:0]      req,
    input  logic [N*20-1:0]   req_data,
    output logic [N-1:0]      ack,
    output logic [24:0]       result_bcd,
    output logic [IDW-1:0]    result_id,
    output logic              result_valid,
    output logic              busy,
    output logic [19:0]       conv_bin,
    input  logic [24:0]       conv_bcd
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(CONV_LAT);

    state_t         state;
    logic [2:0]     cnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;

    logic           found;
    int unsigned    cand;
    int unsigned    pick;
    logic [19:0]    pick_data;

    // First requesting index at or after rr_ptr, wrapping at N.
    always_comb begin
        found = 1'b0;
        cand  = 0;
        pick  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(rr_ptr) + k) % N;
            if (!found && 1'(req >> cand)) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_data = 20'(req_data >> (pick * 20));
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            grant        <= '0;
            conv_bin     <= '0;
            result_bcd   <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
            ack          <= '0;
        end else begin
            result_valid <= 1'b0;
            ack          <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        conv_bin <= pick_data;
                        grant    <= IDW'(pick);
                        cnt      <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAT) begin
                        result_bcd   <= conv_bcd;
                        result_id    <= grant;
                        result_valid <= 1'b1;
                        ack          <= N'(1) << grant;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    rr_ptr <= IDW'((32'(grant) + 1) % N);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Bench for bcd_share_arbiter: converter pipeline model plus a queue of expected tagged results.
module tb_bcd_share_arbiter;

    localparam int N        = 3;
    localparam int IDW      = 2;
    localparam int CONV_LAT = 2;

    logic              Sys_CLK = 1'b0;
    logic              Sys_RST;
    logic [N-1:0]      req;
    logic [N*20-1:0]   req_data;
    logic [N-1:0]      ack;
    logic [24:0]       result_bcd;
    logic [IDW-1:0]    result_id;
    logic              result_valid;
    logic              busy;
    logic [19:0]       conv_bin;
    logic [24:0]       conv_bcd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [24:0]    bcd;
    } exp_t;
    exp_t exp_q[$];

    always #5 Sys_CLK = ~Sys_CLK;

    bcd_share_arbiter #(.N(N), .IDW(IDW), .CONV_LAT(CONV_LAT)) dut (
        .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .req(req), .req_data(req_data),
        .ack(ack), .result_bcd(result_bcd), .result_id(result_id),
        .result_valid(result_valid), .busy(busy), .conv_bin(conv_bin), .conv_bcd(conv_bcd)
    );

    function automatic logic [24:0] bin2bcd(input logic [19:0] v);
        logic [24:0] r;
        int unsigned x;
        r = '0;
        x = 32'(v);
        for (int i = 0; i < 7; i++) begin
            r = r | (25'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    logic [24:0] conv_pipe [CONV_LAT];
    always @(posedge Sys_CLK) begin
        conv_pipe[0] <= bin2bcd(conv_bin);
        for (int i = 1; i < CONV_LAT; i++) conv_pipe[i] <= conv_pipe[i-1];
    end
    assign conv_bcd = conv_pipe[CONV_LAT-1];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int budget, output int waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge Sys_CLK);
            waited++;
            if (result_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        Sys_RST  = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge Sys_CLK);
        checks++; if (result_bcd !== 25'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", result_bcd); end
        checks++; if (result_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", result_id); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=000", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (conv_bin !== 20'h0) begin failures++; $display("FAIL reset_conv_bin got=%h exp=0", conv_bin); end
        Sys_RST = 1'b0;
        @(negedge Sys_CLK);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        int w; bit seen; exp_t e;
        req_data[19:0] = 20'd1234;
        req = 3'b001;
        exp_q.push_back('{id: 2'd0, bcd: 25'h0001234});
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen) begin failures++; $display("FAIL single_timeout got=none exp=result_valid"); end
        checks++; if (w != CONV_LAT + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", w, CONV_LAT + 2); end
        checks++; if (result_bcd !== e.bcd) begin failures++; $display("FAIL single_bcd got=%h exp=%h", result_bcd, e.bcd); end
        checks++; if (result_id !== e.id) begin failures++; $display("FAIL single_id got=%0d exp=%0d", result_id, e.id); end
        checks++; if (ack !== 3'b001) begin failures++; $display("FAIL single_ack got=%b exp=001", ack); end
        req = '0;
        @(negedge Sys_CLK);
        checks++; if (ack !== '0 || result_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=ack %b valid %b exp=000 0", ack, result_valid); end
        checks++; if (result_bcd !== 25'h0001234) begin failures++; $display("FAIL single_hold got=%h exp=0001234", result_bcd); end
    endtask

    task automatic test_extremes;
        int w; bit seen; exp_t e;
        logic [19:0] vals [2];
        logic [24:0] exps [2];
        vals[0] = 20'd1048575; exps[0] = 25'h1048575;
        vals[1] = 20'd0;       exps[1] = 25'h0000000;
        for (int k = 0; k < 2; k++) begin
            req_data[39:20] = vals[k];
            req = 3'b010;
            exp_q.push_back('{id: 2'd1, bcd: exps[k]});
            wait_valid(20, w, seen);
            e = exp_q.pop_front();
            checks++; if (!seen || w != CONV_LAT + 2) begin failures++; $display("FAIL extreme%0d_latency got=%0d seen=%b exp=%0d", k, w, seen, CONV_LAT + 2); end
            checks++; if (result_bcd !== e.bcd) begin failures++; $display("FAIL extreme%0d_bcd got=%h exp=%h", k, result_bcd, e.bcd); end
            checks++; if (result_id !== e.id || ack !== 3'b010) begin failures++; $display("FAIL extreme%0d_id_ack got=%0d/%b exp=%0d/010", k, result_id, ack, e.id); end
            req = '0;
            @(negedge Sys_CLK);
        end
    endtask

    task automatic test_back_to_back;
        int w; bit seen; exp_t e;
        logic [24:0] bcds [3];
        bcds[0] = 25'h59; bcds[1] = 25'h60; bcds[2] = 25'h61;
        Sys_RST = 1'b1;
        @(negedge Sys_CLK);
        Sys_RST = 1'b0;
        req_data[19:0]  = 20'd59;
        req_data[39:20] = 20'd60;
        req_data[59:40] = 20'd61;
        req = 3'b111;
        for (int k = 0; k < 6; k++) exp_q.push_back('{id: 2'(k % 3), bcd: bcds[k % 3]});
        for (int k = 0; k < 6; k++) begin
            wait_valid(20, w, seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen || w != ((k == 0) ? CONV_LAT + 2 : CONV_LAT + 3)) begin
                failures++; $display("FAIL b2b%0d_spacing got=%0d seen=%b exp=%0d", k, w, seen, (k == 0) ? CONV_LAT + 2 : CONV_LAT + 3);
            end
            checks++; if (result_id !== e.id) begin failures++; $display("FAIL b2b%0d_id got=%0d exp=%0d", k, result_id, e.id); end
            checks++; if (result_bcd !== e.bcd) begin failures++; $display("FAIL b2b%0d_bcd got=%h exp=%h", k, result_bcd, e.bcd); end
            checks++; if (ack !== (3'b001 << e.id)) begin failures++; $display("FAIL b2b%0d_ack got=%b exp=%b", k, ack, 3'b001 << e.id); end
        end
        req = '0;
        @(negedge Sys_CLK);
    endtask

    task automatic test_drop_in_wait;
        int w; bit seen; exp_t e; int extra;
        req_data[59:40] = 20'd999999;
        req = 3'b100;
        exp_q.push_back('{id: 2'd2, bcd: 25'h0999999});
        @(negedge Sys_CLK);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b exp=1", busy); end
        req_data[59:40] = 20'd5;
        req = '0;
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen || w != CONV_LAT + 1) begin failures++; $display("FAIL drop_latency got=%0d seen=%b exp=%0d", w, seen, CONV_LAT + 1); end
        checks++; if (result_bcd !== e.bcd) begin failures++; $display("FAIL drop_bcd got=%h exp=%h", result_bcd, e.bcd); end
        checks++; if (result_id !== e.id || ack !== 3'b100) begin failures++; $display("FAIL drop_id_ack got=%0d/%b exp=%0d/100", result_id, ack, e.id); end
        extra = 0;
        repeat (2 * (CONV_LAT + 3)) begin
            @(negedge Sys_CLK);
            if (result_valid !== 1'b0 || ack !== '0 || busy !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL drop_regrant got=%0d active cycles exp=0", extra); end
    endtask

    task automatic test_rr_pointer;
        int w; bit seen; exp_t e;
        req_data[39:20] = 20'd7;
        req = 3'b010;
        exp_q.push_back('{id: 2'd1, bcd: 25'h7});
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen || result_id !== e.id || result_bcd !== e.bcd) begin failures++; $display("FAIL rr_first got=%0d/%h exp=%0d/%h", result_id, result_bcd, e.id, e.bcd); end
        req_data[19:0]  = 20'd100;
        req_data[59:40] = 20'd200;
        req = 3'b101;
        exp_q.push_back('{id: 2'd2, bcd: 25'h200});
        exp_q.push_back('{id: 2'd0, bcd: 25'h100});
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen || w != CONV_LAT + 3) begin failures++; $display("FAIL rr_regrant_latency got=%0d seen=%b exp=%0d", w, seen, CONV_LAT + 3); end
        checks++; if (result_id !== e.id || result_bcd !== e.bcd) begin failures++; $display("FAIL rr_second got=%0d/%h exp=%0d/%h", result_id, result_bcd, e.id, e.bcd); end
        req = 3'b001;
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen || result_id !== e.id || result_bcd !== e.bcd || ack !== 3'b001) begin failures++; $display("FAIL rr_third got=%0d/%h/%b exp=%0d/%h/001", result_id, result_bcd, ack, e.id, e.bcd); end
        req = '0;
        @(negedge Sys_CLK);
    endtask

    task automatic test_async_reset;
        int w; bit seen; exp_t e;
        req_data[59:40] = 20'd555;
        req = 3'b100;
        @(negedge Sys_CLK);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
        #2;
        Sys_RST = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || ack !== '0) begin failures++; $display("FAIL areset_ctrl got=busy %b valid %b ack %b exp=0 0 000", busy, result_valid, ack); end
        checks++; if (result_bcd !== 25'h0 || result_id !== '0) begin failures++; $display("FAIL areset_result got=%h/%0d exp=0/0", result_bcd, result_id); end
        checks++; if (conv_bin !== 20'h0) begin failures++; $display("FAIL areset_conv_bin got=%h exp=0", conv_bin); end
        req_data[19:0]  = 20'd4321;
        req_data[39:20] = 20'd88;
        req = 3'b011;
        @(negedge Sys_CLK);
        Sys_RST = 1'b0;
        exp_q.push_back('{id: 2'd0, bcd: 25'h4321});
        exp_q.push_back('{id: 2'd1, bcd: 25'h88});
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen || w != CONV_LAT + 2) begin failures++; $display("FAIL areset_regrant_latency got=%0d seen=%b exp=%0d", w, seen, CONV_LAT + 2); end
        checks++; if (result_id !== e.id || result_bcd !== e.bcd || ack !== 3'b001) begin failures++; $display("FAIL areset_first got=%0d/%h/%b exp=%0d/%h/001", result_id, result_bcd, ack, e.id, e.bcd); end
        req = 3'b010;
        wait_valid(20, w, seen);
        e = exp_q.pop_front();
        checks++; if (!seen || result_id !== e.id || result_bcd !== e.bcd || ack !== 3'b010) begin failures++; $display("FAIL areset_second got=%0d/%h/%b exp=%0d/%h/010", result_id, result_bcd, ack, e.id, e.bcd); end
        req = '0;
        @(negedge Sys_CLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_drop_in_wait();
        test_rr_pointer();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
